// File: rtl/nec_ir_transmitter.sv
// NEC infrared transmitter: sends a 32-bit word as an NEC frame or a repeat
// code. ir_out is the carrier-modulated LED drive. ir_env is the active-low
// demodulated envelope, which can be looped back into a receiver.
module nec_ir_transmitter #(
    parameter int unsigned UNIT_CYCLES  = 28125,
    parameter int unsigned CARRIER_HALF = 658,
    parameter bit          CARRIER_EN   = 1'b1,
    parameter int unsigned GAP_UNITS    = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rpt,
    input  logic [31:0] word,
    output logic        ir_out,
    output logic        ir_env,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SEG_MAX = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int UW = $clog2(UNIT_CYCLES + 1);
    localparam int CW = $clog2(CARRIER_HALF + 1);
    localparam int SW = $clog2(SEG_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
    } state_t;

    state_t         state_q, state_d;
    logic [UW-1:0]  unit_cnt_q, unit_cnt_d;   // cycle within the current unit
    logic [SW-1:0]  seg_cnt_q, seg_cnt_d;     // unit within the current segment
    logic [5:0]     bit_cnt_q, bit_cnt_d;
    logic [31:0]    shift_q, shift_d;         // MSB is the bit being sent
    logic           rpt_q, rpt_d;             // current frame is a repeat code
    logic [CW-1:0]  car_cnt_q, car_cnt_d;
    logic           car_q, car_d;
    logic           ir_out_q, ir_out_d;
    logic           ir_env_q, ir_env_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [SW-1:0]  seg_units;
    logic           unit_last, seg_last, mark_q, mark_d;

    // Segment timing, frame sequencing, carrier generation and output decode
    always_comb begin
        state_d    = state_q;
        unit_cnt_d = unit_cnt_q;
        seg_cnt_d  = seg_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rpt_d      = rpt_q;
        car_cnt_d  = car_cnt_q;
        car_d      = car_q;

        // Length in units of the segment the current state represents
        case (state_q)
            LEAD_MARK:  seg_units = SW'(16);
            LEAD_SPACE: seg_units = rpt_q ? SW'(4) : SW'(8);
            BIT_SPACE:  seg_units = shift_q[31] ? SW'(3) : SW'(1);
            GAP:        seg_units = SW'(GAP_UNITS);
            default:    seg_units = SW'(1);
        endcase

        unit_last = (unit_cnt_q == UW'(UNIT_CYCLES - 1));
        seg_last  = unit_last && (seg_cnt_q == seg_units - SW'(1));

        // Timer restarts on every state entry and is parked at zero in IDLE
        if (state_q == IDLE || seg_last) begin
            unit_cnt_d = '0;
            seg_cnt_d  = '0;
        end else if (unit_last) begin
            unit_cnt_d = '0;
            seg_cnt_d  = seg_cnt_q + SW'(1);
        end else begin
            unit_cnt_d = unit_cnt_q + UW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LEAD_MARK;
                    shift_d   = word;
                    rpt_d     = 1'b0;
                    bit_cnt_d = '0;
                end else if (rpt) begin
                    state_d = LEAD_MARK;
                    rpt_d   = 1'b1;
                end
            end
            LEAD_MARK:  if (seg_last) state_d = LEAD_SPACE;
            LEAD_SPACE: if (seg_last) state_d = rpt_q ? STOP_MARK : BIT_MARK;
            BIT_MARK:   if (seg_last) state_d = BIT_SPACE;
            BIT_SPACE: begin
                if (seg_last) begin
                    shift_d   = {shift_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK:  if (seg_last) state_d = GAP;
            GAP:        if (seg_last) state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        mark_q = (state_q == LEAD_MARK) || (state_q == BIT_MARK) || (state_q == STOP_MARK);
        mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

        // Carrier phase restarts high on each mark entry, held low otherwise
        if (mark_d && !mark_q) begin
            car_cnt_d = '0;
            car_d     = 1'b1;
        end else if (mark_d) begin
            if (car_cnt_q == CW'(CARRIER_HALF - 1)) begin
                car_cnt_d = '0;
                car_d     = ~car_q;
            end else begin
                car_cnt_d = car_cnt_q + CW'(1);
            end
        end else begin
            car_cnt_d = '0;
            car_d     = 1'b0;
        end

        // Outputs are decoded from the next state so they align with it
        ir_out_d = CARRIER_EN ? car_d : mark_d;
        ir_env_d = ~mark_d;
        busy_d   = (state_d != IDLE);
        done_d   = (state_q == STOP_MARK) && (state_d == GAP);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            unit_cnt_q <= '0;
            seg_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rpt_q      <= 1'b0;
            car_cnt_q  <= '0;
            car_q      <= 1'b0;
            ir_out_q   <= 1'b0;
            ir_env_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rpt_q      <= rpt_d;
            car_cnt_q  <= car_cnt_d;
            car_q      <= car_d;
            ir_out_q   <= ir_out_d;
            ir_env_q   <= ir_env_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ir_out = ir_out_q;
    assign ir_env = ir_env_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
